cpu6_clint: RTL and testbench
=============================

# cpu6_clint

Core-local interrupt source for the cpu6 core. It provides a 64-bit prescaled machine timer with compare, plus a synchronised and optionally edge-latched external interrupt line. It drives the core's `tmr_irq_r` and `ext_irq_r` inputs, gated by the core's `csr_mtie_r` and `csr_meie_r` outputs. Software reaches it through a word-wide memory-mapped window decoded from the core's data port (`dataaddr`/`writedata`/`memwriteM`/`readdata`).

## Interface
- `PRESCALE_RST`, default 0: reset value of the PRESCALE register.
- `SYNC_STAGES`, default 2: flop count of the `ext_irq_in` synchroniser; must be 2 or more.
- `clk` in 1: single clock for all state.
- `reset` in 1: synchronous, active-high. Every register takes its reset value on the first rising edge with `reset`=1.
- `bus_sel` in 1: window selected by the system address decode.
- `bus_we` in 1: write strobe, qualified by `bus_sel`.
- `bus_addr` in 5: byte offset in the window; bits [1:0] ignored.
- `bus_wdata` in 32: write data; full-word writes only.
- `bus_rdata` out 32: read data, combinational from `bus_addr` and current state.
- `csr_mtie_r` in 1: timer interrupt enable from the core.
- `csr_meie_r` in 1: external interrupt enable from the core.
- `ext_irq_in` in 1: asynchronous external interrupt request.
- `tmr_irq_r` out 1: registered timer interrupt to the core. Resets to 0.
- `ext_irq_r` out 1: registered external interrupt to the core. Resets to 0.

## Operation
- Register map (word offsets):
  - 0x00 MTIME_LO, reset 0.
  - 0x04 MTIME_HI, reset 0.
  - 0x08 MTIMECMP_LO, reset 0xFFFF_FFFF.
  - 0x0C MTIMECMP_HI, reset 0xFFFF_FFFF.
  - 0x10 PRESCALE [15:0], reset `PRESCALE_RST`.
  - 0x14 EXT_CTRL: bit0 = edge mode, reset 0.
  - 0x18 EXT_STATUS: bit0 = pending (read), write 1 to clear; bit1 = synced level (read-only).
  - 0x1C and unmapped offsets: read 0, writes ignored.
- Prescaler:
  - 16-bit counter `pcnt`, reset 0.
  - When `pcnt == PRESCALE`, `pcnt` returns to 0 and mtime increments by 1. Otherwise `pcnt` increments.
  - PRESCALE=0 means mtime increments every cycle.
  - A PRESCALE write also clears `pcnt`.
- mtime wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 wraps to 0, with no flag.
- mtime write: a write to either half replaces that half only. The whole increment is suppressed in that cycle; the prescaler keeps counting.
- Read snapshot:
  - A read of MTIME_LO (`bus_sel` & ~`bus_we`) returns live LO and captures live HI into `hi_shadow` at that edge.
  - A read of MTIME_HI returns `hi_shadow`.
  - `hi_shadow` resets to 0.
- Timer interrupt: `tmr_irq_r` <= (mtime >= mtimecmp, 64-bit unsigned) & `csr_mtie_r`, evaluated on current register values every cycle.
- External interrupt:
  - `ext_irq_in` passes through the `SYNC_STAGES` synchroniser, producing `ext_s`.
  - Level mode: pending = `ext_s`, and the clear write has no effect.
  - Edge mode: a rising edge of `ext_s` sets pending. A write of 1 to EXT_STATUS bit0 clears it. A set and a clear in the same cycle leave pending set.
  - Switching edge to level mode clears the latched pending bit.
- `ext_irq_r` <= pending & `csr_meie_r`.

## Timing
- Writes take effect at the rising edge of the write cycle. Reads are same-cycle combinational, matching the core's M-stage load timing.
- The timer interrupt asserts 1 cycle after mtime >= mtimecmp first holds. A write that raises mtimecmp above mtime drops `tmr_irq_r` 1 cycle after the write edge.
- Enable changes (`csr_mtie_r`, `csr_meie_r`) reach the outputs with 1-cycle latency.
- `ext_irq_in` rise to `ext_irq_r` is `SYNC_STAGES`+1 cycles in level mode. Edge mode adds 1 edge-detect flop, giving `SYNC_STAGES`+2.
- Reset mid-count returns all state to reset values at that edge. Outputs are 0 in the cycle after.

## Structure
- Register offsets `CPU6_CLINT_MTIME_LO`…`CPU6_CLINT_EXT_STATUS` belong in the shared `defines.v`, next to the `CPU6_XLEN` constants.
- Sub-module `cpu6_clint_sync`: parameterised N-flop synchroniser with sync reset to 0, reusable for other asynchronous inputs.

## Test plan
- Prescaler: PRESCALE=3, mtime=0, mtimecmp=10, mtie=1 → mtime increments every 4 cycles. `tmr_irq_r` rises exactly 1 cycle after mtime reaches 10.
- Carry and snapshot: write MTIME_HI=0, MTIME_LO=0xFFFF_FFFE with PRESCALE=0 → mtime carries into HI=1. A LO read just before the carry followed by a HI read returns HI=0, proving the snapshot.
- Compare release: `tmr_irq_r`=1, then write MTIMECMP_HI=0xFFFF_FFFF → `tmr_irq_r`=0 one cycle after the write. Toggling mtie with the compare true → output follows with 1-cycle lag.
- Level mode: meie=1, `ext_irq_in` pulsed high for 5 cycles → `ext_irq_r` high for 5 cycles, delayed by 3 cycles.
- Edge mode: a 1-cycle pulse latches pending, and `ext_irq_r` stays 1. A W1C in the same cycle as a new rising edge leaves pending=1; a W1C alone clears it next cycle.
- Reset: assert reset while the count is mid-prescale and `tmr_irq_r`=1 → all registers return to reset values and both outputs read 0 the next cycle.

Source files
------------

// File: rtl/cpu6_clint_pkg.sv
// rtl/cpu6_clint_pkg.sv - shared constants for the cpu6 core-local interrupt block
package cpu6_clint_pkg;

    localparam int CPU6_XLEN = 32;

    // Byte offsets inside the CLINT window; bus_addr[1:0] are ignored on decode.
    localparam logic [4:0] CPU6_CLINT_MTIME_LO    = 5'h00;
    localparam logic [4:0] CPU6_CLINT_MTIME_HI    = 5'h04;
    localparam logic [4:0] CPU6_CLINT_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] CPU6_CLINT_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] CPU6_CLINT_PRESCALE    = 5'h10;
    localparam logic [4:0] CPU6_CLINT_EXT_CTRL    = 5'h14;
    localparam logic [4:0] CPU6_CLINT_EXT_STATUS  = 5'h18;

    function automatic logic [4:0] clint_word(input logic [2:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/cpu6_clint_sync.sv
// rtl/cpu6_clint_sync.sv - N-flop synchroniser for asynchronous single-bit inputs
module cpu6_clint_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/cpu6_clint.sv
// rtl/cpu6_clint.sv - prescaled 64-bit machine timer and external interrupt source for cpu6
module cpu6_clint
    import cpu6_clint_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RST = 16'd0,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bus_sel,
    input  logic                 bus_we,
    input  logic [4:0]           bus_addr,
    input  logic [CPU6_XLEN-1:0] bus_wdata,
    output logic [CPU6_XLEN-1:0] bus_rdata,
    input  logic                 csr_mtie_r,
    input  logic                 csr_meie_r,
    input  logic                 ext_irq_in,
    output logic                 tmr_irq_r,
    output logic                 ext_irq_r
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [15:0] prescale;
    logic [15:0] pcnt;
    logic [31:0] hi_shadow;
    logic        edge_mode;
    logic        pend_q;
    logic        ext_s;
    logic        ext_s_d;
    logic        pending;
    logic        tick;
    logic [4:0]  word;
    logic        wr;
    logic        rd;
    logic        unused_addr;

    assign word        = clint_word(bus_addr[4:2]);
    assign unused_addr = ^bus_addr[1:0];
    assign wr          = bus_sel & bus_we;
    assign rd          = bus_sel & ~bus_we;
    assign tick        = (pcnt == prescale);
    assign pending     = edge_mode ? pend_q : ext_s;

    cpu6_clint_sync #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk  (clk),
        .reset(reset),
        .d    (ext_irq_in),
        .q    (ext_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            prescale  <= PRESCALE_RST;
            pcnt      <= '0;
            hi_shadow <= '0;
            edge_mode <= 1'b0;
            pend_q    <= 1'b0;
            ext_s_d   <= 1'b0;
            tmr_irq_r <= 1'b0;
            ext_irq_r <= 1'b0;
        end else begin
            if (wr && word == CPU6_CLINT_PRESCALE) begin
                prescale <= bus_wdata[15:0];
                pcnt     <= '0;
            end else begin
                pcnt <= tick ? 16'd0 : pcnt + 16'd1;
            end

            // A write to either half wins over the tick; the prescaler is not held.
            if (wr && word == CPU6_CLINT_MTIME_LO) begin
                mtime[31:0] <= bus_wdata;
            end else if (wr && word == CPU6_CLINT_MTIME_HI) begin
                mtime[63:32] <= bus_wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wr && word == CPU6_CLINT_MTIMECMP_LO) mtimecmp[31:0]  <= bus_wdata;
            if (wr && word == CPU6_CLINT_MTIMECMP_HI) mtimecmp[63:32] <= bus_wdata;
            if (wr && word == CPU6_CLINT_EXT_CTRL)    edge_mode       <= bus_wdata[0];

            // LO read freezes HI so a LO-then-HI sequence sees a coherent 64-bit value.
            if (rd && word == CPU6_CLINT_MTIME_LO) hi_shadow <= mtime[63:32];

            ext_s_d <= ext_s;
            if (!edge_mode || (wr && word == CPU6_CLINT_EXT_CTRL && !bus_wdata[0])) begin
                pend_q <= 1'b0;
            end else if (ext_s && !ext_s_d) begin
                pend_q <= 1'b1;
            end else if (wr && word == CPU6_CLINT_EXT_STATUS && bus_wdata[0]) begin
                pend_q <= 1'b0;
            end

            tmr_irq_r <= (mtime >= mtimecmp) & csr_mtie_r;
            ext_irq_r <= pending & csr_meie_r;
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (word)
            CPU6_CLINT_MTIME_LO:    bus_rdata = mtime[31:0];
            CPU6_CLINT_MTIME_HI:    bus_rdata = hi_shadow;
            CPU6_CLINT_MTIMECMP_LO: bus_rdata = mtimecmp[31:0];
            CPU6_CLINT_MTIMECMP_HI: bus_rdata = mtimecmp[63:32];
            CPU6_CLINT_PRESCALE:    bus_rdata = {16'd0, prescale};
            CPU6_CLINT_EXT_CTRL:    bus_rdata = {31'd0, edge_mode};
            CPU6_CLINT_EXT_STATUS:  bus_rdata = {30'd0, ext_s, pending};
            default:                bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu6_clint.sv
// tb/tb_cpu6_clint.sv - self-checking bench for cpu6_clint
module tb_cpu6_clint;
    import cpu6_clint_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_sel;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        csr_mtie_r;
    logic        csr_meie_r;
    logic        ext_irq_in;
    logic        tmr_irq_r;
    logic        ext_irq_r;

    int checks   = 0;
    int failures = 0;

    cpu6_clint #(
        .PRESCALE_RST(16'd0),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .csr_mtie_r(csr_mtie_r),
        .csr_meie_r(csr_meie_r),
        .ext_irq_in(ext_irq_in),
        .tmr_irq_r (tmr_irq_r),
        .ext_irq_r (ext_irq_r)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        step();
        bus_sel = 1'b0; bus_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    // Number of timer ticks on edges 3..n after a PRESCALE write at edge 0
    // (edges 1 and 2 carry mtime writes and never increment).
    function automatic int ticks_upto(input int n, input int p);
        int c = 0;
        for (int k = 3; k <= n; k++) if (k % (p + 1) == 0) c++;
        return c;
    endfunction

    task automatic test_reset();
        logic [4:0]  ra [8];
        logic [31:0] re [8];
        logic [31:0] d;
        ra = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
        re = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (tmr_irq_r !== 1'b0) begin failures++; $display("FAIL reset_tmr got=%0b exp=0", tmr_irq_r); end
        checks++;
        if (ext_irq_r !== 1'b0) begin failures++; $display("FAIL reset_ext got=%0b exp=0", ext_irq_r); end
        for (int i = 0; i < 8; i++) begin
            rd(ra[i], d);
            checks++;
            if (d !== re[i]) begin failures++; $display("FAIL reset_reg[%h] got=%h exp=%h", ra[i], d, re[i]); end
        end
        wr(5'h1C, $urandom);
        rd(5'h1C, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", d); end
        rd(5'h0B, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addr_lowbits got=%h exp=ffffffff", d); end
    endtask

    task automatic test_prescaler(input int p, input logic [31:0] base, input int delta);
        logic [63:0] exp_now;
        logic [63:0] exp_prev;
        logic [63:0] cmp;
        cmp = 64'(base) + 64'(delta);
        csr_mtie_r = 1'b1;
        wr(CPU6_CLINT_PRESCALE, 32'(p));
        wr(CPU6_CLINT_MTIME_HI, 32'h0);
        wr(CPU6_CLINT_MTIME_LO, base);
        wr(CPU6_CLINT_MTIMECMP_LO, cmp[31:0]);
        wr(CPU6_CLINT_MTIMECMP_HI, 32'h0);
        bus_addr = CPU6_CLINT_MTIME_LO;
        for (int n = 5; n <= 5 + (p + 1) * (delta + 3); n++) begin
            step();
            exp_now  = 64'(base) + 64'(ticks_upto(n, p));
            exp_prev = 64'(base) + 64'(ticks_upto(n - 1, p));
            checks++;
            if (bus_rdata !== exp_now[31:0]) begin
                failures++; $display("FAIL prescale_mtime p=%0d n=%0d got=%h exp=%h", p, n, bus_rdata, exp_now[31:0]);
            end
            checks++;
            if (tmr_irq_r !== (exp_prev >= cmp)) begin
                failures++; $display("FAIL prescale_tmr p=%0d n=%0d got=%0b exp=%0b", p, n, tmr_irq_r, exp_prev >= cmp);
            end
        end
    endtask

    task automatic test_carry(input logic [31:0] h);
        logic [31:0] d;
        wr(CPU6_CLINT_PRESCALE, 32'h0);
        wr(CPU6_CLINT_MTIME_HI, h);
        wr(CPU6_CLINT_MTIME_LO, 32'hFFFF_FFFE);
        bus_sel = 1'b1; bus_we = 1'b0;
        rd(CPU6_CLINT_MTIME_LO, d);
        checks++;
        if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL carry_lo0 got=%h exp=fffffffe", d); end
        step();
        rd(CPU6_CLINT_MTIME_LO, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL carry_lo1 got=%h exp=ffffffff", d); end
        step();
        bus_sel = 1'b0;
        rd(CPU6_CLINT_MTIME_HI, d);
        checks++;
        if (d !== h) begin failures++; $display("FAIL snapshot_hi got=%h exp=%h", d, h); end
        rd(CPU6_CLINT_MTIME_LO, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL carry_lo_wrap got=%h exp=0", d); end
        bus_sel = 1'b1;
        step();
        bus_sel = 1'b0;
        rd(CPU6_CLINT_MTIME_HI, d);
        checks++;
        if (d !== h + 32'd1) begin failures++; $display("FAIL carry_hi got=%h exp=%h", d, h + 32'd1); end
        rd(CPU6_CLINT_MTIME_LO, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL carry_lo_next got=%h exp=1", d); end
    endtask

    task automatic test_compare();
        logic m;
        csr_mtie_r = 1'b1;
        wr(CPU6_CLINT_PRESCALE, 32'hFFFF);
        wr(CPU6_CLINT_MTIME_HI, 32'h0);
        wr(CPU6_CLINT_MTIME_LO, 32'd100);
        wr(CPU6_CLINT_MTIMECMP_LO, 32'd50);
        wr(CPU6_CLINT_MTIMECMP_HI, 32'h0);
        step();
        checks++;
        if (tmr_irq_r !== 1'b1) begin failures++; $display("FAIL cmp_true got=%0b exp=1", tmr_irq_r); end
        wr(CPU6_CLINT_MTIMECMP_HI, 32'hFFFF_FFFF);
        checks++;
        if (tmr_irq_r !== 1'b1) begin failures++; $display("FAIL cmp_write_edge got=%0b exp=1", tmr_irq_r); end
        step();
        checks++;
        if (tmr_irq_r !== 1'b0) begin failures++; $display("FAIL cmp_release got=%0b exp=0", tmr_irq_r); end
        wr(CPU6_CLINT_MTIMECMP_HI, 32'h0);
        step();
        checks++;
        if (tmr_irq_r !== 1'b1) begin failures++; $display("FAIL cmp_rearm got=%0b exp=1", tmr_irq_r); end
        for (int i = 0; i < 12; i++) begin
            m = 1'($urandom_range(0, 1));
            csr_mtie_r = m;
            step();
            checks++;
            if (tmr_irq_r !== m) begin failures++; $display("FAIL mtie_lag i=%0d got=%0b exp=%0b", i, tmr_irq_r, m); end
        end
        csr_mtie_r = 1'b1;
    endtask

    task automatic test_level();
        logic        xs [48];
        logic        ms [48];
        logic [31:0] d;
        csr_meie_r = 1'b1;
        ext_irq_in = 1'b0;
        repeat (3) step();
        for (int c = 0; c < 48; c++) begin
            xs[c] = (c >= 3 && c < 8) ? 1'b1 : (c < 11 ? 1'b0 : 1'($urandom_range(0, 1)));
            ms[c] = (c < 20) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        // Output in cycle c reflects the input three cycles earlier and the enable one cycle earlier.
        for (int c = 0; c < 48; c++) begin
            ext_irq_in = xs[c];
            csr_meie_r = ms[c];
            if (c >= 3) begin
                checks++;
                if (ext_irq_r !== (xs[c-3] & ms[c-1])) begin
                    failures++; $display("FAIL level_irq c=%0d got=%0b exp=%0b", c, ext_irq_r, xs[c-3] & ms[c-1]);
                end
            end
            if (c >= 2) begin
                rd(CPU6_CLINT_EXT_STATUS, d);
                checks++;
                if (d[1:0] !== {xs[c-2], xs[c-2]}) begin
                    failures++; $display("FAIL level_status c=%0d got=%b exp=%b", c, d[1:0], {xs[c-2], xs[c-2]});
                end
            end
            step();
        end
        ext_irq_in = 1'b0;
        csr_meie_r = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_edge();
        logic [31:0] d;
        wr(CPU6_CLINT_EXT_CTRL, 32'h1);
        ext_irq_in = 1'b1; step(); ext_irq_in = 1'b0;
        step(); step();
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b1) begin failures++; $display("FAIL edge_pend_set got=%0b exp=1", d[0]); end
        checks++;
        if (ext_irq_r !== 1'b0) begin failures++; $display("FAIL edge_latency got=%0b exp=0", ext_irq_r); end
        step();
        checks++;
        if (ext_irq_r !== 1'b1) begin failures++; $display("FAIL edge_irq_rise got=%0b exp=1", ext_irq_r); end
        repeat ($urandom_range(3, 8)) begin
            step();
            checks++;
            if (ext_irq_r !== 1'b1) begin failures++; $display("FAIL edge_irq_hold got=%0b exp=1", ext_irq_r); end
        end
        wr(CPU6_CLINT_EXT_STATUS, 32'h1);
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b0) begin failures++; $display("FAIL w1c_clear got=%0b exp=0", d[0]); end
        step();
        checks++;
        if (ext_irq_r !== 1'b0) begin failures++; $display("FAIL w1c_irq_drop got=%0b exp=0", ext_irq_r); end
        ext_irq_in = 1'b1; step(); ext_irq_in = 1'b0;
        step();
        wr(CPU6_CLINT_EXT_STATUS, 32'h1);
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b1) begin failures++; $display("FAIL w1c_vs_set got=%0b exp=1", d[0]); end
        step();
        checks++;
        if (ext_irq_r !== 1'b1) begin failures++; $display("FAIL w1c_vs_set_irq got=%0b exp=1", ext_irq_r); end
        wr(CPU6_CLINT_EXT_STATUS, 32'h0);
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b1) begin failures++; $display("FAIL w0_no_effect got=%0b exp=1", d[0]); end
        wr(CPU6_CLINT_EXT_CTRL, 32'h0);
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b0) begin failures++; $display("FAIL to_level got=%0b exp=0", d[0]); end
        wr(CPU6_CLINT_EXT_CTRL, 32'h1);
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b0) begin failures++; $display("FAIL latch_cleared got=%0b exp=0", d[0]); end
        wr(CPU6_CLINT_EXT_CTRL, 32'h0);
        ext_irq_in = 1'b1;
        repeat (3) step();
        wr(CPU6_CLINT_EXT_STATUS, 32'h1);
        rd(CPU6_CLINT_EXT_STATUS, d);
        checks++;
        if (d[0] !== 1'b1) begin failures++; $display("FAIL level_w1c_ignored got=%0b exp=1", d[0]); end
        ext_irq_in = 1'b0;
        repeat (3) step();
        wr(CPU6_CLINT_EXT_CTRL, 32'h1);
    endtask

    task automatic test_reset_mid();
        logic [4:0]  ra [7];
        logic [31:0] re [7];
        logic [31:0] d;
        ra = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};
        re = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        csr_mtie_r = 1'b1;
        csr_meie_r = 1'b1;
        ext_irq_in = 1'b1; step(); ext_irq_in = 1'b0;
        repeat (4) step();
        wr(CPU6_CLINT_MTIME_HI, 32'h1234_5678);
        bus_sel = 1'b1; bus_we = 1'b0; bus_addr = CPU6_CLINT_MTIME_LO;
        step();
        bus_sel = 1'b0;
        wr(CPU6_CLINT_PRESCALE, 32'd3);
        wr(CPU6_CLINT_MTIMECMP_HI, 32'h0);
        wr(CPU6_CLINT_MTIMECMP_LO, 32'h0);
        step(); step();
        checks++;
        if ({tmr_irq_r, ext_irq_r} !== 2'b11) begin failures++; $display("FAIL pre_reset got=%b exp=11", {tmr_irq_r, ext_irq_r}); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({tmr_irq_r, ext_irq_r} !== 2'b00) begin failures++; $display("FAIL post_reset_irq got=%b exp=00", {tmr_irq_r, ext_irq_r}); end
        for (int i = 0; i < 7; i++) begin
            rd(ra[i], d);
            checks++;
            if (d !== re[i]) begin failures++; $display("FAIL post_reset_reg[%h] got=%h exp=%h", ra[i], d, re[i]); end
        end
        step();
        rd(CPU6_CLINT_MTIME_LO, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL pcnt_reset got=%h exp=1", d); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        csr_mtie_r = 1'b0; csr_meie_r = 1'b0; ext_irq_in = 1'b0;
        test_reset();
        test_prescaler(3, 32'd0, 10);
        test_prescaler($urandom_range(0, 4), 32'($urandom_range(0, 1000)), $urandom_range(1, 8));
        test_prescaler(0, 32'($urandom_range(0, 1000)), $urandom_range(1, 8));
        test_carry(32'($urandom_range(0, 32'h7FFF_FFFF)));
        test_carry(32'hFFFF_FFFF);
        test_compare();
        test_level();
        test_edge();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
